// File: rtl/muldiv_sequencer.sv
// Iterative M-extension unit: shift-add multiplier and restoring divider behind a
// one-request-at-a-time valid/ready handshake. Word ops run 32 iterations and sign-extend.
module muldiv_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return {{(XLEN-32){1'b0}}, v};
  endfunction

  // Control state
  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_result;

  // Datapath: r_x = multiplicand / dividend-quotient shifter, r_y = multiplier / divisor,
  // r_acc = product accumulator / partial remainder.
  logic [XLEN-1:0] r_x;
  logic [XLEN-1:0] r_y;
  logic [XLEN-1:0] r_acc;
  logic            r_is_div;
  logic            r_is_rem;
  logic            r_word;
  logic            r_neg_q;
  logic            r_neg_r;

  // Accept-time decode
  logic            w_accept;
  logic            w_is_div;
  logic            w_is_signed;
  logic            w_is_rem;
  logic [XLEN-1:0] w_a_ext;
  logic [XLEN-1:0] w_b_ext;
  logic [XLEN-1:0] w_most_neg;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_overflow;
  logic            w_special;
  logic [XLEN-1:0] w_special_raw;
  logic [XLEN-1:0] w_special_res;

  assign req_ready_o  = (r_state == S_IDLE) && !flush_i;
  assign resp_valid_o = (r_state == S_DONE);
  assign busy_o       = (r_state != S_IDLE);
  assign result_o     = r_result;

  assign w_accept    = req_valid_i && req_ready_o;
  assign w_is_div    = funct3_i[2];
  assign w_is_signed = !funct3_i[0];
  assign w_is_rem    = funct3_i[1];

  assign w_a_ext = !word_i ? a_i : (w_is_signed ? sext32(a_i[31:0]) : zext32(a_i[31:0]));
  assign w_b_ext = !word_i ? b_i : (w_is_signed ? sext32(b_i[31:0]) : zext32(b_i[31:0]));
  assign w_most_neg = word_i ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};

  assign w_a_neg = w_is_div && w_is_signed && w_a_ext[XLEN-1];
  assign w_b_neg = w_is_div && w_is_signed && w_b_ext[XLEN-1];
  assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

  assign w_div_zero = w_is_div && (w_b_ext == '0);
  assign w_overflow = w_is_div && w_is_signed && (w_a_ext == w_most_neg) && (w_b_ext == '1);
  assign w_special  = w_div_zero || w_overflow;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_special_raw = '0;
    if (w_div_zero) begin
      w_special_raw = w_is_rem ? w_a_ext : '1;
    end else if (w_overflow) begin
      w_special_raw = w_is_rem ? '0 : w_most_neg;
    end
  end

  assign w_special_res = word_i ? sext32(w_special_raw[31:0]) : w_special_raw;

  // One iteration of either engine, computed from the current datapath registers
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;
  logic [XLEN-1:0] w_acc_nxt;
  logic [XLEN-1:0] w_x_nxt;
  logic [XLEN-1:0] w_y_nxt;

  assign w_rem_sh = {r_acc, r_x[XLEN-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_y});
  // The true difference is below 2^XLEN whenever it is used, so the low bits suffice.
  assign w_sub    = w_rem_sh[XLEN-1:0] - r_y;

  always_comb begin
    w_acc_nxt = r_acc;
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    if (r_is_div) begin
      w_acc_nxt = w_ge ? w_sub : w_rem_sh[XLEN-1:0];
      w_x_nxt   = {r_x[XLEN-2:0], w_ge};
    end else begin
      w_acc_nxt = r_acc + (r_y[0] ? r_x : '0);
      w_x_nxt   = r_x << 1;
      w_y_nxt   = r_y >> 1;
    end
  end

  // The last iteration and the result write share one edge, so finalize from next values.
  logic [XLEN-1:0] w_quot;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_final_raw;
  logic [XLEN-1:0] w_final;

  assign w_quot      = r_neg_q ? -w_x_nxt : w_x_nxt;
  assign w_rem       = r_neg_r ? -w_acc_nxt : w_acc_nxt;
  assign w_final_raw = !r_is_div ? w_acc_nxt : (r_is_rem ? w_rem : w_quot);
  assign w_final     = r_word ? sext32(w_final_raw[31:0]) : w_final_raw;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= word_i ? CW'(32) : CW'(XLEN);
            if (w_special) begin
              r_state  <= S_DONE;
              r_result <= w_special_res;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state  <= S_DONE;
            r_result <= w_final;
          end
        end
        S_DONE: begin
          if (resp_ready_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded at accept before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_is_div <= w_is_div;
      r_is_rem <= w_is_rem;
      r_word   <= word_i;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_acc    <= '0;
      if (w_is_div) begin
        r_x <= word_i ? {w_a_mag[31:0], {(XLEN-32){1'b0}}} : w_a_mag;
        r_y <= w_b_mag;
      end else begin
        r_x <= a_i;
        r_y <= b_i;
      end
    end else if (r_state == S_BUSY) begin
      r_acc <= w_acc_nxt;
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, multi-cycle corner
// sequences (flush, back-pressure, async reset) and random ops against an arithmetic model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  funct3_i;
  logic        word_i;
  logic [63:0] a_i;
  logic [63:0] b_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [63:0] result_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_sequencer #(.XLEN(64)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .funct3_i     (funct3_i),
    .word_i       (word_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .result_o     (result_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference model: plain arithmetic on the architectural operand values.
  task automatic model(input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output int lat);
    logic [63:0] ua, ub, q, r, min_v, prod;
    logic signed [63:0] sa, sb, sq, sr;
    lat = w ? 33 : 65;
    if (!f[2]) begin
      prod = a * b;
      res  = w ? sx(prod[31:0]) : prod;
      return;
    end
    if (w) begin
      ua = f[0] ? {32'b0, a[31:0]} : sx(a[31:0]);
      ub = f[0] ? {32'b0, b[31:0]} : sx(b[31:0]);
    end else begin
      ua = a;
      ub = b;
    end
    min_v = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    if (ub == 64'd0) begin
      q = '1; r = ua; lat = 1;
    end else if (f[0]) begin
      q = ua / ub; r = ua % ub;
    end else if (ua == min_v && ub == '1) begin
      q = ua; r = 64'd0; lat = 1;
    end else begin
      sa = ua; sb = ub;
      sq = sa / sb; sr = sa % sb;
      q = sq; r = sr;
    end
    res = f[1] ? r : q;
    if (w) res = sx(res[31:0]);
  endtask

  task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b);
    @(negedge clk);
    funct3_i = f; word_i = w; a_i = a; b_i = b; req_valid_i = 1'b1;
    #1;
    check("req_ready_before_accept", {63'b0, req_ready_o}, 64'd1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  // Latency counts the cycle right after the accept edge as 1.
  task automatic wait_resp(output int lat);
    int busy_low = 0;
    lat = 1;
    while (!resp_valid_o && lat < 100) begin
      if (!busy_o) busy_low++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!busy_o) busy_low++;
    check("busy_low_while_pending", 64'(busy_low), 64'd0);
    if (!resp_valid_o) begin
      n_errors++;
      $display("FAIL resp_timeout: resp_valid_o never rose within %0d cycles", lat);
    end
  endtask

  task automatic complete();
    @(negedge clk);
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1 resp_ready_i = 1'b0;
    check("idle_after_handshake", {61'b0, resp_valid_o, busy_o, req_ready_o}, 64'b001);
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    issue(f, w, a, b);
    wait_resp(lat);
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_result"}, result_o, exp);
    complete();
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [63:0] exp, held;
    int lat, valid_seen;
    logic [2:0] fsel[5];

    resetn = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b0;
    funct3_i = 3'b000; word_i = 1'b0; a_i = '0; b_i = '0;
    fsel = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111};

    #12;
    check("reset_outputs", {61'b0, req_ready_o, resp_valid_o, busy_o}, 64'b100);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    vecs.push_back('{"mul_7_m3",     3'b000, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65});
    vecs.push_back('{"divw_m7_2",    3'b100, 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33});
    vecs.push_back('{"remw_m7_2",    3'b110, 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33});
    vecs.push_back('{"divu_by0",     3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    vecs.push_back('{"rem_by0",      3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 1});
    vecs.push_back('{"div_ovf",      3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1});
    vecs.push_back('{"rem_ovf",      3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1});
    vecs.push_back('{"divw_ovf",     3'b100, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0001_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{"remuw_by0",    3'b111, 1'b1, 64'hAAAA_0000_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 1});
    vecs.push_back('{"divuw_max",    3'b101, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'hABCD_0000_0000_0002, 64'h0000_0000_7FFF_FFFF, 33});
    vecs.push_back('{"remuw_max",    3'b111, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'hABCD_0000_0000_0002, 64'd1, 33});
    vecs.push_back('{"mulw_sext",    3'b000, 1'b1, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_8000, 64'hFFFF_FFFF_8000_0000, 33});
    vecs.push_back('{"divu_max_10",  3'b101, 1'b0, '1, 64'd10, 64'h1999_9999_9999_9999, 65});
    vecs.push_back('{"remu_max_10",  3'b111, 1'b0, '1, 64'd10, 64'd5, 65});
    vecs.push_back('{"div_m100_7",   3'b100, 1'b0, -64'sd100, 64'd7, -64'sd14, 65});
    vecs.push_back('{"rem_m100_7",   3'b110, 1'b0, -64'sd100, 64'd7, -64'sd2, 65});

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].f, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Flush mid-divide: no response may ever appear.
    issue(3'b100, 1'b0, 64'd100, 64'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    check("flush_to_idle", {62'b0, busy_o, resp_valid_o}, 64'b00);
    valid_seen = 0;
    repeat (70) begin
      @(posedge clk);
      #1 if (resp_valid_o) valid_seen++;
    end
    check("flush_no_resp", 64'(valid_seen), 64'd0);

    // Request coincident with flush is refused.
    @(negedge clk);
    flush_i = 1'b1; req_valid_i = 1'b1; funct3_i = 3'b000; word_i = 1'b0; a_i = 64'd9; b_i = 64'd9;
    #1 check("req_ready_under_flush", {63'b0, req_ready_o}, 64'd0);
    @(posedge clk);
    #1 begin flush_i = 1'b0; req_valid_i = 1'b0; end
    check("flush_req_not_accepted", {63'b0, busy_o}, 64'd0);
    run_op("mul_3_4_after_flush", 3'b000, 1'b0, 64'd3, 64'd4, 64'd12, 65);

    // Back-pressure in DONE: result and handshake outputs hold.
    issue(3'b000, 1'b0, 64'h1234, 64'h10);
    wait_resp(lat);
    held = result_o;
    check("hold_result", held, 64'h12340);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("hold_stable", result_o, held);
      check("hold_flags", {61'b0, req_ready_o, resp_valid_o, busy_o}, 64'b011);
    end
    complete();

    // Asynchronous reset mid-BUSY.
    issue(3'b101, 1'b0, 64'd1000, 64'd3);
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("async_reset_flags", {61'b0, req_ready_o, resp_valid_o, busy_o}, 64'b100);
    check("async_reset_result", result_o, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("divu_after_reset", 3'b101, 1'b0, 64'd1000, 64'd3, 64'd333, 65);

    // Random ops against the model, biased toward the special cases.
    for (int n = 0; n < 40; n++) begin
      logic [2:0] f;
      logic w;
      logic [63:0] a, b;
      int sel;
      f   = fsel[$urandom_range(0, 4)];
      w   = 1'($urandom_range(0, 1));
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      sel = $urandom_range(0, 7);
      if (sel == 0) b = w ? {b[63:32], 32'd0} : 64'd0;
      else if (sel == 1) begin
        a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = w ? {b[63:32], 32'hFFFF_FFFF} : '1;
      end else if (sel == 2) b = 64'($urandom_range(1, 100));
      else if (sel == 3) a = 64'($urandom_range(0, 1000));
      model(f, w, a, b, exp, lat);
      run_op($sformatf("rand%0d_f%0d_w%0d", n, f, w), f, w, a, b, exp, lat);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
